// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: single-cycle byte pulses in, FWFT valid/ready out.
// Define UART_RX_FIFO_OVF_CNT_EN to add the saturating ovf_count register/port.
module uart_rx_fifo #(
  parameter int PAYLOAD_BITS = 8,
  parameter int DEPTH_LOG2   = 4,
  parameter int AFULL_LEVEL  = 12
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  input  logic                    in_break,
  input  logic [PAYLOAD_BITS-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_break,
  output logic [DEPTH_LOG2:0]     level,
  output logic                    almost_full,
  output logic                    overflow,
  input  logic                    ovf_clear
`ifdef UART_RX_FIFO_OVF_CNT_EN
  ,
  output logic [7:0]              ovf_count
`endif
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_L =
    (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AFULL_L =
    (DEPTH_LOG2+1)'(AFULL_LEVEL);

  logic [PAYLOAD_BITS:0]   mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0]   rd_q, rd_d;
  logic [DEPTH_LOG2-1:0]   wr_q, wr_d;
  logic [DEPTH_LOG2:0]     level_q, level_d;
  logic                    ovf_q, ovf_d;
  logic                    full;
  logic                    pop;
  logic                    push_ok;
  logic                    drop;

  assign full    = (level_q == DEPTH_L);
  assign pop     = out_valid & out_ready;
  // A simultaneous pop frees a slot, so a full FIFO still accepts.
  assign push_ok = in_valid & (~full | pop);
  assign drop    = in_valid & full & ~pop;

  always_comb begin
    rd_d    = rd_q;
    wr_d    = wr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    if (pop)     rd_d = rd_q + 1'b1;
    if (push_ok) wr_d = wr_q + 1'b1;
    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
    if (drop)           ovf_d = 1'b1;
    else if (ovf_clear) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= {in_break, in_data};
  end

`ifdef UART_RX_FIFO_OVF_CNT_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (drop) begin
      if (ovf_clear)           cnt_d = 8'd1;
      else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end else if (ovf_clear) begin
      cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

  assign ovf_count = cnt_q;
`endif

  assign out_valid   = (level_q != '0);
  assign out_data    = mem_q[rd_q][PAYLOAD_BITS-1:0];
  assign out_break   = mem_q[rd_q][PAYLOAD_BITS];
  assign level       = level_q;
  assign almost_full = (level_q >= AFULL_L);
  assign overflow    = ovf_q;

endmodule
